pipe_latch: RTL and testbench
=============================

# pipe_latch

Parametrised successor to the fixed FD/DX/XM/MW/PW stage latches. It is a generic inter-stage pipeline register carrying one instruction word plus `NUM_FIELDS` data fields of `DATA_W` bits each. It adds a per-entry valid bit, a valid/ready handshake in both directions, bubble (NOP) presentation and synchronous flush. An optional 2-entry skid buffer decouples backpressure, so stall logic no longer has to reach every upstream latch combinationally.

## Interface
- `DATA_W`, 32, width of each payload field.
- `NUM_FIELDS`, 3, number of payload fields (PC/A/B, O/B, O/D, and so on).
- `NOP_IR`, 32'h0000_0000, instruction word presented on `out_ir` when no valid entry is present.

- `clock` in 1: single clock. All state updates on the falling edge, as in the existing stage latches.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `in_valid` in 1: upstream offers an entry.
- `in_ready` out 1: latch can accept an entry.
- `in_ir` in 32: upstream instruction word.
- `in_data` in `NUM_FIELDS*DATA_W`: upstream payload. Field *k* occupies bits [*k*·`DATA_W` +: `DATA_W`].
- `flush` in 1: discard all held entries and any entry offered this cycle.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: downstream consumes the head entry.
- `out_ir` out 32: head instruction word, or `NOP_IR` when `out_valid`=0.
- `out_data` out `NUM_FIELDS*DATA_W`: head payload, all zeros when `out_valid`=0.
- `occupancy` out 2: number of valid entries (0–2).

## Operation
- Push occurs when `in_valid` & `in_ready` at a falling edge. Pop occurs when `out_valid` & `out_ready` at a falling edge.
- Entries leave in arrival order (FIFO). The head entry drives the outputs.
- `flush`=1 at an edge sets occupancy to 0. Flush overrides any simultaneous push and pop: the offered entry is dropped and nothing counts as consumed downstream.
- Push and pop at the same edge leave occupancy unchanged. If occupancy was 1, the new entry becomes the head.
- Pop at occupancy 2 promotes the second entry to head. The payload moves unchanged.
- No push is accepted when full. No pop occurs when empty (`out_valid`=0).
- Reset low: occupancy is 0, `out_valid`=0, `out_ir`=`NOP_IR`, `out_data`=0, `occupancy`=0. `in_ready` is 1 as soon as reset is released. Reset asserted mid-operation discards all entries immediately, with no edge required.
- Data registers clear to zero on reset and on flush. A bubble therefore never leaks stale operands.

## Timing
- Latency: an entry pushed at falling edge *n* is visible on the outputs (`out_valid`=1) directly after edge *n*.
- Throughput: 1 entry per cycle while `out_ready`=1.
- `out_valid`, `out_ir`, `out_data` and `occupancy` are driven from registers only. None of them depends combinationally on any input.
- `in_ready` depends on the configuration (see below).
- `occupancy` updates on the same edge as the push, pop or flush that changes it.

## Configuration
- Macro: `PIPE_LATCH_SKID_EN`.
- Defined: 2-entry storage.
  - `in_ready` = (occupancy < 2), registered, with no combinational path from `out_ready`.
  - The latch absorbs one extra entry after downstream stalls.
  - `occupancy` ranges 0–2.
- Undefined: 1-entry storage, equivalent to the existing stage latches.
  - `in_ready` = (occupancy == 0) | `out_ready`, which is a combinational pass-through of backpressure.
  - `occupancy` never exceeds 1.
  - The second-entry registers are not built.

## Structure
- Shared package `pipe_pkg` contains:
  - the `NOP_IR` default constant (all-zero NOP encoding);
  - the 2-bit occupancy type;
  - a helper function that extracts field *k* from a packed payload.
- Sub-module `pipe_entry_reg` holds one entry: valid bit, 32-bit IR and packed payload, with load-enable and synchronous clear. It is instantiated once, or twice with `PIPE_LATCH_SKID_EN`.
- The top level contains only the head/tail pointers (or a shift control), the occupancy counter and the ready/valid logic.

## Test plan
- **Reset mid-stream.** With 2 entries held, drive `reset` low between edges.
  - Required: `out_valid`=0, `out_ir`=32'h0, `occupancy`=0 immediately.
  - Required: after release, `in_ready`=1.
- **Streaming.** Push IR 0x0001_0000..0x0001_0007 with `out_ready`=1 held.
  - Required: each appears one edge after its push, in order, with no gaps.
  - Required: `occupancy` stays at 1.
- **Stall, skid defined.** Drop `out_ready` while streaming.
  - Required: the next offered entry is still accepted, `occupancy`=2, `in_ready`=0.
  - Required: on `out_ready`=1, entries drain in order and no word is lost or duplicated.
- **Stall, skid undefined.** Same stimulus as the previous scenario.
  - Required: `in_ready` falls in the same cycle as `out_ready`.
  - Required: `occupancy` never exceeds 1.
- **Flush with push.** At occupancy 1, assert `flush` together with `in_valid`=1 and IR 0xDEAD_0001.
  - Required: after the edge, `occupancy`=0, `out_ir`=`NOP_IR`, `out_data`=0.
  - Required: 0xDEAD_0001 never appears on `out_ir`.
- **Simultaneous push and pop.** At occupancy 1 with head IR 0xA, push 0xB and pop on the same edge.
  - Required: `occupancy`=1 and `out_ir`=0xB.
  - Required: each field *k* of `out_data` equals the pushed field *k* (use `NUM_FIELDS`=4, `DATA_W`=16).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipe_latch inter-stage register.
package pipe_pkg;

    localparam logic [31:0] NOP_IR_DEFAULT = 32'h0000_0000;
    localparam int          PAYLOAD_MAX_W  = 512;
    localparam int          FIELD_MAX_W    = 64;

    typedef logic [1:0] occ_t;

    // Field k of a packed payload whose fields are w bits wide.
    function automatic logic [FIELD_MAX_W-1:0] get_field(
        input logic [PAYLOAD_MAX_W-1:0] data,
        input int unsigned              k,
        input int unsigned              w
    );
        logic [PAYLOAD_MAX_W-1:0] shifted;
        logic [PAYLOAD_MAX_W-1:0] mask;
        shifted = data >> (k * w);
        mask    = (PAYLOAD_MAX_W'(1) << w) - PAYLOAD_MAX_W'(1);
        return FIELD_MAX_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/pipe_latch_if.sv
// Valid/ready bundle between an upstream stage, the latch and the downstream stage.
interface pipe_latch_if
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 3
);
    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  in_ir;
    logic [NUM_FIELDS*DATA_W-1:0] in_data;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    logic [31:0]                  out_ir;
    logic [NUM_FIELDS*DATA_W-1:0] out_data;
    occ_t                         occupancy;

    modport master (
        output in_valid, in_ir, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ir, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_ir, in_data, flush, out_ready,
        output in_ready, out_valid, out_ir, out_data, occupancy
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// One latch entry: valid bit, instruction word and packed payload.
// Clear wins over load so a flush can never leave a half-loaded entry.
module pipe_entry_reg #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clr_i,
    input  logic                         ld_i,
    input  logic [31:0]                  ir_i,
    input  logic [NUM_FIELDS*DATA_W-1:0] data_i,
    output logic                         valid_o,
    output logic [31:0]                  ir_o,
    output logic [NUM_FIELDS*DATA_W-1:0] data_o
);
    logic                         valid_q;
    logic [31:0]                  ir_q;
    logic [NUM_FIELDS*DATA_W-1:0] data_q;

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            data_q  <= '0;
        end else if (ld_i) begin
            valid_q <= 1'b1;
            ir_q    <= ir_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ir_o    = ir_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_latch.sv
// Generic falling-edge pipeline latch with valid/ready handshake and flush.
// PIPE_LATCH_SKID_EN adds a second entry and a registered in_ready.
module pipe_latch
    import pipe_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          NUM_FIELDS = 3,
    parameter logic [31:0] NOP_IR     = NOP_IR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    pipe_latch_if.slave bus
);
    localparam int PW = NUM_FIELDS * DATA_W;

    logic          push;
    logic          pop;
    logic          head_valid;
    logic [31:0]   head_ir;
    logic [PW-1:0] head_data;
    logic          head_ld;
    logic          head_clr;
    logic [31:0]   head_ir_d;
    logic [PW-1:0] head_data_d;
    occ_t          occ_q;
    occ_t          occ_d;

`ifdef PIPE_LATCH_SKID_EN
    logic          in_ready_q;
    logic          tail_valid;
    logic [31:0]   tail_ir;
    logic [PW-1:0] tail_data;
    logic          tail_ld;
    logic          tail_clr;

    assign bus.in_ready = in_ready_q;

    // Head refills from the tail when one is held, otherwise from the input.
    assign head_ld     = (pop & (tail_valid | push)) | (push & ~head_valid);
    assign head_clr    = bus.flush | (pop & ~tail_valid & ~push);
    assign head_ir_d   = tail_valid ? tail_ir   : bus.in_ir;
    assign head_data_d = tail_valid ? tail_data : bus.in_data;
    assign tail_ld     = push & head_valid & ~pop;
    assign tail_clr    = bus.flush | (pop & tail_valid);

    pipe_entry_reg #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS)) u_tail (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (tail_clr),
        .ld_i    (tail_ld),
        .ir_i    (bus.in_ir),
        .data_i  (bus.in_data),
        .valid_o (tail_valid),
        .ir_o    (tail_ir),
        .data_o  (tail_data)
    );

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (occ_d != 2'd2);
        end
    end
`else
    assign bus.in_ready = (occ_q == 2'd0) | bus.out_ready;
    assign head_ld      = push;
    assign head_clr     = bus.flush | (pop & ~push);
    assign head_ir_d    = bus.in_ir;
    assign head_data_d  = bus.in_data;
`endif

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = head_valid & bus.out_ready;

    pipe_entry_reg #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS)) u_head (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (head_clr),
        .ld_i    (head_ld),
        .ir_i    (head_ir_d),
        .data_i  (head_data_d),
        .valid_o (head_valid),
        .ir_o    (head_ir),
        .data_o  (head_data)
    );

    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = 2'd0;
        end else if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Head data is already zero whenever the head is empty; only the IR needs the NOP mux.
    assign bus.out_valid = head_valid;
    assign bus.out_ir    = head_valid ? head_ir : NOP_IR;
    assign bus.out_data  = head_data;
    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_pipe_latch.sv
// Self-checking bench for pipe_latch: vector table plus scoreboard queue model.
module tb_pipe_latch;
    import pipe_pkg::*;

    localparam int DW = 16;
    localparam int NF = 4;

    typedef struct packed {
        logic [31:0] ir;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        logic        v;
        logic [31:0] ir;
        logic [63:0] d;
        logic        fl;
        logic        ordy;
        logic [1:0]  occ;
    } vec_t;

    logic clock;
    logic reset;
    ent_t q[$];
    int   n_vec;
    int   n_err;
    logic last_ready;

    pipe_latch_if #(.DATA_W(DW), .NUM_FIELDS(NF)) bus ();

    pipe_latch #(.DATA_W(DW), .NUM_FIELDS(NF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic        exp_v;
        logic [31:0] exp_ir;
        logic [63:0] exp_d;
        if (q.size() > 0) begin
            exp_v  = 1'b1;
            exp_ir = q[0].ir;
            exp_d  = q[0].data;
        end else begin
            exp_v  = 1'b0;
            exp_ir = NOP_IR_DEFAULT;
            exp_d  = '0;
        end
        chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
        chk("out_ir", 64'(bus.out_ir), 64'(exp_ir));
        chk("out_data", bus.out_data, exp_d);
        chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
    endtask

    // One cycle: drive between edges, check in_ready, then check outputs after the falling edge.
    task automatic step(input logic v, input logic [31:0] ir, input logic [63:0] d,
                        input logic fl, input logic ordy, output logic acc);
        logic exp_rdy;
        logic push;
        logic pop;
        @(posedge clock);
        bus.in_valid  = v;
        bus.in_ir     = ir;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
`ifdef PIPE_LATCH_SKID_EN
        exp_rdy = (q.size() < 2);
`else
        exp_rdy = (q.size() == 0) || ordy;
`endif
        last_ready = bus.in_ready;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        push = v && exp_rdy;
        pop  = (q.size() > 0) && ordy;
        acc  = push && !fl;
        @(negedge clock);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({ir, d});
        end
        check_outputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[14];
        logic        acc;
        logic [63:0] data_b;
        logic [15:0] pat;
        int          sent;
        int          max_occ;
        logic        ordy;

        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ir     = '0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 32'h0001_0000 + 32'(i),
                       {16'(i), 16'hC0DE, 16'(i * 3), 16'hBEEF}, 1'b0, 1'b1, 2'd1};
        end
        tbl[8]  = '{1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 2'd0};
        tbl[9]  = '{1'b1, 32'h0000_000A, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 2'd1};
        tbl[10] = '{1'b1, 32'h0000_000B, 64'h5555_6666_7777_8888, 1'b0, 1'b1, 2'd1};
        tbl[11] = '{1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 2'd1};
        tbl[12] = '{1'b1, 32'hDEAD_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 2'd0};
        tbl[13] = '{1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 2'd0};

        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_ir", 64'(bus.out_ir), 64'(NOP_IR_DEFAULT));
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        reset = 1'b1;
        #1;
        chk("rst_release_in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].ir, tbl[i].d, tbl[i].fl, tbl[i].ordy, acc);
            chk("vec_occ", 64'(bus.occupancy), 64'(tbl[i].occ));
        end

        // Simultaneous push and pop at occupancy 1: the new word becomes head intact.
        data_b = 64'hAAAA_BBBB_CCCC_DDDD;
        step(1'b1, 32'h0000_000A, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h0000_000B, data_b, 1'b0, 1'b1, acc);
        chk("pushpop_occ", 64'(bus.occupancy), 64'd1);
        chk("pushpop_ir", 64'(bus.out_ir), 64'h0000_000B);
        for (int k = 0; k < NF; k++) begin
            chk("pushpop_field",
                get_field(PAYLOAD_MAX_W'(bus.out_data), k, DW),
                get_field(PAYLOAD_MAX_W'(data_b), k, DW));
        end
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, acc);

        // Stall while streaming: out_ready low for three cycles, then drain.
        pat     = 16'b1111_1111_1110_0011;
        sent    = 0;
        max_occ = 0;
        for (int c = 0; c < 20; c++) begin
            ordy = (c < 16) ? pat[c] : 1'b1;
            step(sent < 6, 32'h0002_0000 + 32'(sent), {32'(sent), 32'h5A5A_0000 + 32'(sent)},
                 1'b0, ordy, acc);
            if (acc) sent++;
            if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
            if (c == 2) begin
`ifdef PIPE_LATCH_SKID_EN
                chk("stall_skid_occ", 64'(bus.occupancy), 64'd2);
                chk("stall_skid_in_ready", 64'(bus.in_ready), 64'd0);
`else
                chk("stall_same_cycle_ready", 64'(last_ready), 64'd0);
                chk("stall_noskid_occ", 64'(bus.occupancy), 64'd1);
`endif
            end
        end
`ifdef PIPE_LATCH_SKID_EN
        chk("stall_max_occ", 64'(max_occ), 64'd2);
`else
        chk("stall_max_occ", 64'(max_occ), 64'd1);
`endif
        chk("stall_drained_occ", 64'(bus.occupancy), 64'd0);

        // Reset asserted between edges with entries held.
        step(1'b1, 32'h0003_0000, 64'h0000_0000_0003_0000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h0003_0001, 64'h0000_0000_0003_0001, 1'b0, 1'b0, acc);
        @(posedge clock);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_ir", 64'(bus.out_ir), 64'h0);
        chk("midrst_out_data", bus.out_data, 64'd0);
        chk("midrst_occupancy", 64'(bus.occupancy), 64'd0);
        @(negedge clock);
        @(posedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_release_in_ready", 64'(bus.in_ready), 64'd1);
        step(1'b1, 32'h0004_0000, 64'h0004_0004_0004_0004, 1'b0, 1'b1, acc);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
